spi_reg_slave: RTL and testbench
================================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter ADDR_W, default 7, register address width in bits.
REQ-002 Parameter DATA_W, default 64, register word width in bits.
REQ-003 Parameter CPOL, default 0, SCK idle level.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 sck, mosi, cs  in  1 each  raw SPI pins, asynchronous to clk; cs is active low.
REQ-008 miso  out  1  serial read data, MSB first.
REQ-009 miso_oe  out  1  MISO output enable.
REQ-010 addr  out  ADDR_W  current word address.
REQ-011 data_in  out  DATA_W  last complete word written by the master.
REQ-012 data_out  in  DATA_W  register read data for addr; valid the cycle after rd_en.
REQ-013 wr_en, rd_en, frame_err  out  1 each  single-cycle pulses.
REQ-014 busy  out  1  high while a frame is in progress (state not IDLE).

Function
REQ-015 sck, mosi and cs SHALL each pass through a 2-flop synchronizer; SCK edges SHALL be detected from the synchronized value.
REQ-016 Supported clk/sck ratio SHALL be at least 16.
REQ-017 The sample edge is rising when CPOL==CPHA, falling otherwise; the opposite edge is the shift edge.
REQ-018 FSM states: IDLE, HDR, DATA.
  - IDLE->HDR on synchronized cs falling edge.
  - HDR->DATA after ADDR_W+1 sampled bits.
  - Any state->IDLE on cs rising edge.
REQ-019 Header format, MSB first: ADDR_W address bits, then 1 direction bit (1 = write, 0 = read).
REQ-020 Header completes at cycle T. At T+1, addr SHALL take the header address. If the direction bit is 0 (read), rd_en SHALL also pulse at T+1.
REQ-021 Write word completes (DATA_W bits sampled) at cycle T:
  - T+1: data_in SHALL take the word, and wr_en SHALL pulse with addr equal to the word's address.
  - T+2: addr SHALL increment by 1.
REQ-022 Read load, for a rd_en pulse at cycle R: at R+1 the MISO shift register SHALL load data_out. Loaded bits are then presented MSB first, one bit per shift edge.
REQ-023 Read word completes at cycle T: at T+1, addr SHALL increment by 1 and rd_en SHALL pulse (prefetch for burst).
REQ-024 CPHA=0 read: the loaded MSB SHALL appear on miso at the load cycle, before the next sample edge.
REQ-025 Header phase: miso SHALL be 0.
REQ-026 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0), with no error.
REQ-027 miso_oe SHALL equal the inverse of synchronized cs; miso SHALL be 0 while miso_oe is 0.
REQ-028 cs rising with a nonzero bit count in HDR or DATA:
  - the partial word SHALL be discarded, with no wr_en;
  - frame_err SHALL pulse for 1 cycle;
  - state SHALL go to IDLE.
REQ-029 cs rising exactly on a word boundary SHALL NOT assert frame_err.
REQ-030 A sample edge and a cs rise in the same cycle: the cs rise wins and the bit is ignored.
REQ-031 SCK edges while cs is high SHALL be ignored.

Reset
REQ-032 On rst_n low, all of the following SHALL reset immediately, even mid-frame:
  - state to IDLE;
  - addr, data_in, shift registers and bit counter to 0;
  - miso, miso_oe, wr_en, rd_en, frame_err and busy to 0.
REQ-033 After rst_n release with cs already low, the block SHALL stay IDLE until cs goes high and then low again.

Verification (ADDR_W=7, DATA_W=8, clk = 16x sck)
REQ-034 Mode 0 write burst: header 0x15 with W=1, then data 0xA5, 0x3C, then cs high -> wr_en twice: first (addr 0x15, data_in 0xA5), then (addr 0x16, data_in 0x3C); frame_err stays 0.
REQ-035 Mode 3 read burst: header 0x20 with W=0, bench returns 0x5A for addr 0x20 and 0xC3 for addr 0x21, 16 clocks -> miso bits 0x5A then 0xC3; rd_en pulses at addrs 0x20, 0x21, 0x22.
REQ-036 Wrap: mode 1 write at header 0x7F, two words 0x01, 0x02 -> wr_en at addr 0x7F, then at addr 0x00.
REQ-037 Abort: mode 2 write at 0x10, one full word 0xFF plus 3 bits, then cs high -> exactly one wr_en (0x10, 0xFF), one frame_err pulse, state IDLE.
REQ-038 Reset mid-frame: rst_n low during the 4th data bit with cs held low, then release -> all outputs 0; no wr_en until a new cs fall; the next full frame works normally.

Source files
------------

// File: rtl/spi_reg_slave_if.sv
// SPI pin and register-bus bundle for spi_reg_slave.
`timescale 1ns/1ps
interface spi_reg_slave_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 64
) ();
    logic              sck;
    logic              mosi;
    logic              cs;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              wr_en;
    logic              rd_en;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sck, mosi, cs, data_out,
        output miso, miso_oe, addr, data_in, wr_en, rd_en, frame_err, busy
    );

    modport master (
        output sck, mosi, cs, data_out,
        input  miso, miso_oe, addr, data_in, wr_en, rd_en, frame_err, busy
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI slave exposing a word-addressed register bus with auto-incrementing bursts.
// Header is ADDR_W address bits then a write flag; each following word is one register.
`timescale 1ns/1ps
module spi_reg_slave #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 64,
    parameter bit          CPOL   = 1'b0,
    parameter bit          CPHA   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    spi_reg_slave_if.slave bus
);

    localparam int unsigned RX_W    = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int unsigned CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit          SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    logic [1:0] sck_s, mosi_s, cs_s;
    logic       sck_d, cs_d;
    logic       sck_sync, mosi_sync, cs_sync;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       sample_edge, shift_edge;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [RX_W-1:0]   rx;
    logic [DATA_W-1:0] tx;
    logic              is_write;
    logic              rd_pend;
    logic              inc_pend;
    logic              miso, miso_oe, wr_en, rd_en, frame_err, busy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s  <= '0;
            mosi_s <= '0;
            cs_s   <= '0;
            sck_d  <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sck_s  <= {sck_s[0], bus.sck};
            mosi_s <= {mosi_s[0], bus.mosi};
            cs_s   <= {cs_s[0], bus.cs};
            sck_d  <= sck_s[1];
            cs_d   <= cs_s[1];
        end
    end

    assign sck_sync    = sck_s[1];
    assign mosi_sync   = mosi_s[1];
    assign cs_sync     = cs_s[1];
    assign sck_rise    = sck_sync & ~sck_d;
    assign sck_fall    = ~sck_sync & sck_d;
    assign cs_rise     = cs_sync & ~cs_d;
    assign cs_fall     = ~cs_sync & cs_d;
    assign sample_edge = ~cs_sync & (SAMPLE_RISE ? sck_rise : sck_fall);
    assign shift_edge  = ~cs_sync & (SAMPLE_RISE ? sck_fall : sck_rise);

    // Frame FSM, receive/transmit shifters and register-bus strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            is_write  <= 1'b0;
            rd_pend   <= 1'b0;
            inc_pend  <= 1'b0;
            addr      <= '0;
            data_in   <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            frame_err <= 1'b0;
            inc_pend  <= 1'b0;
            rd_pend   <= rd_en;
            miso_oe   <= ~cs_sync;
            if (inc_pend) begin
                addr <= addr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        state   <= HDR;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        rx      <= '0;
                        tx      <= '0;
                    end
                end

                HDR, DATA: begin
                    if (cs_rise) begin
                        // A partial word is dropped; only a mid-word abort is an error
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                        rx        <= '0;
                        miso      <= 1'b0;
                        frame_err <= (bit_cnt != '0);
                    end else if (state == HDR) begin
                        miso <= 1'b0;
                        if (sample_edge) begin
                            if (bit_cnt == CNT_W'(ADDR_W)) begin
                                addr     <= rx[ADDR_W-1:0];
                                is_write <= mosi_sync;
                                rd_en    <= ~mosi_sync;
                                state    <= DATA;
                                bit_cnt  <= '0;
                                rx       <= '0;
                            end else begin
                                rx      <= {rx[RX_W-2:0], mosi_sync};
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end else begin
                        if (sample_edge) begin
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                bit_cnt <= '0;
                                rx      <= '0;
                                if (is_write) begin
                                    data_in  <= {rx[DATA_W-2:0], mosi_sync};
                                    wr_en    <= 1'b1;
                                    inc_pend <= 1'b1;
                                end else begin
                                    addr  <= addr + ADDR_W'(1);
                                    rd_en <= 1'b1;
                                end
                            end else begin
                                rx      <= {rx[RX_W-2:0], mosi_sync};
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // With CPHA=0 the MSB is driven at load, so the shift edge
                        // right after a word boundary must not advance the shifter
                        if (rd_pend) begin
                            if (CPHA) begin
                                tx <= bus.data_out;
                            end else begin
                                miso <= bus.data_out[DATA_W-1];
                                tx   <= {bus.data_out[DATA_W-2:0], 1'b0};
                            end
                        end else if (shift_edge && (CPHA || (bit_cnt != '0))) begin
                            miso <= tx[DATA_W-1];
                            tx   <= {tx[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miso      = miso;
    assign bus.miso_oe   = miso_oe;
    assign bus.addr      = addr;
    assign bus.data_in   = data_in;
    assign bus.wr_en     = wr_en;
    assign bus.rd_en     = rd_en;
    assign bus.frame_err = frame_err;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: one instance per SPI mode, ADDR_W=7, DATA_W=8, clk = 16x sck.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [1:0]    dut;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]    sck, mosi, cs;
    logic [3:0]    miso_a, oe_a, wr_a, rd_a, err_a, busy_a;
    logic [AW-1:0] addr_a [4];
    logic [DW-1:0] din_a  [4];
    logic [DW-1:0] mem    [128];

    ev_t exp_wr[$], exp_rd[$], exp_err[$], exp_miso[$], obs_miso[$];
    int  n_pass = 0;
    int  n_total = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam bit P_CPOL = 1'(g / 2);
        localparam bit P_CPHA = 1'(g % 2);
        spi_reg_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] rdata;

        // Register file model: data valid the cycle after rd_en
        always_ff @(posedge clk) begin
            if (bus.rd_en) rdata <= mem[bus.addr];
        end

        assign bus.sck      = sck[g];
        assign bus.mosi     = mosi[g];
        assign bus.cs       = cs[g];
        assign bus.data_out = rdata;
        assign miso_a[g]    = bus.miso;
        assign oe_a[g]      = bus.miso_oe;
        assign wr_a[g]      = bus.wr_en;
        assign rd_a[g]      = bus.rd_en;
        assign err_a[g]     = bus.frame_err;
        assign busy_a[g]    = bus.busy;
        assign addr_a[g]    = bus.addr;
        assign din_a[g]     = bus.data_in;

        spi_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .CPOL(P_CPOL), .CPHA(P_CPHA)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endfunction

    function automatic void unexpected(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL unexpected_%s: got 0x%0h required no event", name, act);
    endfunction

    function automatic ev_t ev(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        e.dut  = 2'(m);
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic logic cpol(input int m);
        return 1'(m / 2);
    endfunction

    function automatic logic cpha(input int m);
        return 1'(m % 2);
    endfunction

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_low(input int m);
        cs[m] = 1'b0;
        half();
    endtask

    task automatic cs_high(input int m);
        half();
        cs[m] = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    // Master side: shifts n bits MSB first and samples miso on the mode's sample edge
    task automatic shift_bits(input int m, input int n, input logic [31:0] bits, output logic [31:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha(m)) begin
                mosi[m] = bits[i];
                half();
                sck[m] = ~cpol(m);
                got = {got[30:0], miso_a[m]};
                half();
                sck[m] = cpol(m);
            end else begin
                sck[m]  = ~cpol(m);
                mosi[m] = bits[i];
                half();
                sck[m] = cpol(m);
                got = {got[30:0], miso_a[m]};
                half();
            end
        end
    endtask

    task automatic frame(input int m, input int n, input logic [31:0] bits);
        logic [31:0] got;
        logic [31:0] sh;
        cs_low(m);
        shift_bits(m, n, bits, got);
        cs_high(m);
        for (int k = 0; k < n / 8; k++) begin
            sh = got >> (n - 8 * (k + 1));
            obs_miso.push_back(ev(m, '0, sh[7:0]));
        end
    endtask

    // Monitor: every DUT strobe and every captured miso byte pops one expectation
    initial begin
        ev_t o;
        ev_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (wr_a[g]) begin
                    o = ev(g, addr_a[g], din_a[g]);
                    if (exp_wr.size() == 0) unexpected("wr_en", 32'(o));
                    else begin e = exp_wr.pop_front(); check("wr_en", 32'(o), 32'(e)); end
                end
                if (rd_a[g]) begin
                    o = ev(g, addr_a[g], '0);
                    if (exp_rd.size() == 0) unexpected("rd_en", 32'(o));
                    else begin e = exp_rd.pop_front(); check("rd_en", 32'(o), 32'(e)); end
                end
                if (err_a[g]) begin
                    o = ev(g, '0, '0);
                    if (exp_err.size() == 0) unexpected("frame_err", 32'(o));
                    else begin e = exp_err.pop_front(); check("frame_err", 32'(o), 32'(e)); end
                end
            end
            while (obs_miso.size() > 0) begin
                o = obs_miso.pop_front();
                if (exp_miso.size() == 0) unexpected("miso_byte", 32'(o));
                else begin e = exp_miso.pop_front(); check("miso_byte", 32'(o), 32'(e)); end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] got;
        rst_n = 1'b0;
        cs    = 4'hF;
        mosi  = 4'h0;
        sck   = 4'b1100;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[7'h20] = 8'h5A;
        mem[7'h21] = 8'hC3;
        mem[7'h22] = 8'h99;

        repeat (4) @(negedge clk);
        for (int g = 0; g < 4; g++)
            check($sformatf("reset_outputs_dut%0d", g),
                  32'({addr_a[g], din_a[g], miso_a[g], oe_a[g], wr_a[g], rd_a[g], err_a[g], busy_a[g]}), 32'(0));
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_oe_busy", 32'({oe_a, busy_a}), 32'(0));

        // SCK toggling with cs high must not start anything
        for (int i = 0; i < 4; i++) begin sck[0] = ~sck[0]; half(); end
        check("sck_while_cs_high_busy", 32'(busy_a[0]), 32'(0));

        // Mode 0 write burst at 0x15
        exp_wr.push_back(ev(0, 7'h15, 8'hA5));
        exp_wr.push_back(ev(0, 7'h16, 8'h3C));
        repeat (3) exp_miso.push_back(ev(0, '0, 8'h00));
        frame(0, 24, 32'({8'h2B, 8'hA5, 8'h3C}));
        check("mode0_final_addr", 32'(addr_a[0]), 32'(7'h17));
        check("mode0_busy_after", 32'(busy_a[0]), 32'(0));

        // Mode 3 read burst at 0x20 with prefetch
        exp_rd.push_back(ev(3, 7'h20, '0));
        exp_rd.push_back(ev(3, 7'h21, '0));
        exp_rd.push_back(ev(3, 7'h22, '0));
        exp_miso.push_back(ev(3, '0, 8'h00));
        exp_miso.push_back(ev(3, '0, 8'h5A));
        exp_miso.push_back(ev(3, '0, 8'hC3));
        frame(3, 24, 32'({8'h40, 8'h00, 8'h00}));
        check("mode3_final_addr", 32'(addr_a[3]), 32'(7'h22));

        // Mode 1 write wrapping from 0x7F to 0x00
        exp_wr.push_back(ev(1, 7'h7F, 8'h01));
        exp_wr.push_back(ev(1, 7'h00, 8'h02));
        repeat (3) exp_miso.push_back(ev(1, '0, 8'h00));
        frame(1, 24, 32'({8'hFF, 8'h01, 8'h02}));
        check("mode1_wrap_addr", 32'(addr_a[1]), 32'(7'h01));

        // Mode 2 abort after one word plus three bits
        exp_wr.push_back(ev(2, 7'h10, 8'hFF));
        exp_err.push_back(ev(2, '0, '0));
        repeat (2) exp_miso.push_back(ev(2, '0, 8'h00));
        frame(2, 19, 32'({8'h21, 8'hFF, 3'b101}));
        check("mode2_abort_busy", 32'(busy_a[2]), 32'(0));
        check("mode2_abort_addr", 32'(addr_a[2]), 32'(7'h11));

        // Reset during the 4th data bit of a mode 0 write with cs held low
        cs_low(0);
        shift_bits(0, 11, 32'({8'h61, 3'b011}), got);
        mosi[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset_dut0",
              32'({addr_a[0], din_a[0], miso_a[0], oe_a[0], wr_a[0], rd_a[0], err_a[0], busy_a[0]}), 32'(0));
        check("midframe_reset_busy_all", 32'(busy_a), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sck[0] = 1'b1;
        half();
        sck[0] = 1'b0;
        shift_bits(0, 4, 32'h5, got);
        check("post_reset_stays_idle", 32'(busy_a[0]), 32'(0));
        cs_high(0);

        exp_wr.push_back(ev(0, 7'h30, 8'h77));
        repeat (2) exp_miso.push_back(ev(0, '0, 8'h00));
        frame(0, 16, 32'({8'h61, 8'h77}));
        check("post_reset_frame_addr", 32'(addr_a[0]), 32'(7'h31));

        repeat (10) @(negedge clk);
        check("leftover_wr", 32'(exp_wr.size()), 32'(0));
        check("leftover_rd", 32'(exp_rd.size()), 32'(0));
        check("leftover_err", 32'(exp_err.size()), 32'(0));
        check("leftover_miso", 32'(exp_miso.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
